// File: rtl/axi4s_pkt_buffer.sv
// axi4s_pkt_buffer: first-word-fall-through AXI4-Stream beat FIFO with an
// ingress-side packet monitor that reports beats, bytes, ID, destination and
// protocol-error status for every completed packet.
module axi4s_pkt_buffer #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int MAX_BEATS = 256
) (
    input  logic                      ACLK,
    input  logic                      RST,
    input  logic                      S_TVALID,
    output logic                      S_TREADY,
    input  logic [DATA_W-1:0]         S_TDATA,
    input  logic [DATA_W/8-1:0]       S_TKEEP,
    input  logic                      S_TLAST,
    input  logic [1:0]                S_TDEST,
    input  logic [7:0]                S_TID,
    output logic                      M_TVALID,
    input  logic                      M_TREADY,
    output logic [DATA_W-1:0]         M_TDATA,
    output logic [DATA_W/8-1:0]       M_TKEEP,
    output logic                      M_TLAST,
    output logic [1:0]                M_TDEST,
    output logic [7:0]                M_TID,
    output logic [$clog2(DEPTH):0]    FIFO_LEVEL,
    output logic                      PKT_DONE,
    output logic [8:0]                PKT_BEATS,
    output logic [10:0]               PKT_BYTES,
    output logic [7:0]                PKT_TID,
    output logic [1:0]                PKT_TDEST,
    output logic                      PKT_ERR
);

    localparam int KEEP_W  = DATA_W / 8;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = DATA_W + KEEP_W + 1 + 2 + 8;

    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);
    localparam logic [8:0]       BEATS_CAP  = 9'(MAX_BEATS);
    localparam logic [11:0]      BYTES_CAP  = 12'(MAX_BEATS * KEEP_W);

    typedef enum logic {IDLE, IN_PKT} mon_state_t;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level;
    logic               ready_en;
    logic               push;
    logic               pop;

    mon_state_t  state, state_nxt;
    logic [8:0]  beats, beats_nxt;
    logic [10:0] bytes, bytes_nxt;
    logic [7:0]  ref_tid, ref_tid_nxt;
    logic [1:0]  ref_tdest, ref_tdest_nxt;
    logic        err, err_nxt;
    logic        done_nxt;
    logic [10:0] keep_cnt;
    logic [11:0] byte_sum;

    function automatic logic [10:0] popcount(input logic [KEEP_W-1:0] v);
        logic [10:0] n;
        n = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            n = n + {10'd0, v[i]};
        end
        return n;
    endfunction

    // ready_en keeps S_TREADY low during reset and for the release cycle
    assign S_TREADY   = ready_en && (level != FULL_LEVEL);
    assign M_TVALID   = (level != '0);
    assign push       = S_TVALID && S_TREADY;
    assign pop        = M_TVALID && M_TREADY;
    assign FIFO_LEVEL = level;
    assign head       = mem[rd_ptr];
    assign {M_TDATA, M_TKEEP, M_TLAST, M_TDEST, M_TID} = M_TVALID ? head : '0;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge ACLK or posedge RST) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Beat storage, written unmodified on every accepted ingress beat
    always_ff @(posedge ACLK) begin
        if (push) begin
            mem[wr_ptr] <= {S_TDATA, S_TKEEP, S_TLAST, S_TDEST, S_TID};
        end
    end

    // Monitor state register plus running packet counters and published stats
    always_ff @(posedge ACLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            beats     <= '0;
            bytes     <= '0;
            ref_tid   <= '0;
            ref_tdest <= '0;
            err       <= 1'b0;
            PKT_DONE  <= 1'b0;
            PKT_BEATS <= '0;
            PKT_BYTES <= '0;
            PKT_TID   <= '0;
            PKT_TDEST <= '0;
            PKT_ERR   <= 1'b0;
        end else begin
            state     <= state_nxt;
            beats     <= beats_nxt;
            bytes     <= bytes_nxt;
            ref_tid   <= ref_tid_nxt;
            ref_tdest <= ref_tdest_nxt;
            err       <= err_nxt;
            PKT_DONE  <= done_nxt;
            if (done_nxt) begin
                PKT_BEATS <= beats_nxt;
                PKT_BYTES <= bytes_nxt;
                PKT_TID   <= ref_tid_nxt;
                PKT_TDEST <= ref_tdest_nxt;
                PKT_ERR   <= err_nxt;
            end
        end
    end

    // Next-state and counter update for each accepted ingress beat
    always_comb begin
        state_nxt     = state;
        beats_nxt     = beats;
        bytes_nxt     = bytes;
        ref_tid_nxt   = ref_tid;
        ref_tdest_nxt = ref_tdest;
        err_nxt       = err;
        done_nxt      = 1'b0;
        keep_cnt      = popcount(S_TKEEP);
        byte_sum      = {1'b0, bytes} + {1'b0, keep_cnt};
        if (push) begin
            case (state)
                IDLE: begin
                    ref_tid_nxt   = S_TID;
                    ref_tdest_nxt = S_TDEST;
                    beats_nxt     = 9'd1;
                    bytes_nxt     = keep_cnt;
                    err_nxt       = 1'b0;
                    state_nxt     = S_TLAST ? IDLE : IN_PKT;
                    done_nxt      = S_TLAST;
                end
                IN_PKT: begin
                    if (beats == BEATS_CAP) begin
                        err_nxt = 1'b1;
                    end else begin
                        beats_nxt = beats + 9'd1;
                    end
                    bytes_nxt = (byte_sum > BYTES_CAP) ? BYTES_CAP[10:0] : byte_sum[10:0];
                    if ((S_TID != ref_tid) || (S_TDEST != ref_tdest)) begin
                        err_nxt = 1'b1;
                    end
                    if (S_TLAST) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4s_pkt_buffer.sv
// tb_axi4s_pkt_buffer: directed and randomized stimulus against a queue-based
// reference model of the packet buffer and its per-packet statistics.
module tb_axi4s_pkt_buffer;

    localparam int DATA_W    = 32;
    localparam int DEPTH     = 16;
    localparam int MAX_BEATS = 256;
    localparam int MAX_BYTES = MAX_BEATS * DATA_W / 8;

    logic        ACLK = 1'b0;
    logic        RST;
    logic        S_TVALID;
    logic        S_TREADY;
    logic [31:0] S_TDATA;
    logic [3:0]  S_TKEEP;
    logic        S_TLAST;
    logic [1:0]  S_TDEST;
    logic [7:0]  S_TID;
    logic        M_TVALID;
    logic        M_TREADY;
    logic [31:0] M_TDATA;
    logic [3:0]  M_TKEEP;
    logic        M_TLAST;
    logic [1:0]  M_TDEST;
    logic [7:0]  M_TID;
    logic [4:0]  FIFO_LEVEL;
    logic        PKT_DONE;
    logic [8:0]  PKT_BEATS;
    logic [10:0] PKT_BYTES;
    logic [7:0]  PKT_TID;
    logic [1:0]  PKT_TDEST;
    logic        PKT_ERR;

    always #5 ACLK = ~ACLK;

    axi4s_pkt_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_BEATS(MAX_BEATS)) dut (
        .ACLK(ACLK), .RST(RST),
        .S_TVALID(S_TVALID), .S_TREADY(S_TREADY), .S_TDATA(S_TDATA), .S_TKEEP(S_TKEEP),
        .S_TLAST(S_TLAST), .S_TDEST(S_TDEST), .S_TID(S_TID),
        .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .M_TDATA(M_TDATA), .M_TKEEP(M_TKEEP),
        .M_TLAST(M_TLAST), .M_TDEST(M_TDEST), .M_TID(M_TID),
        .FIFO_LEVEL(FIFO_LEVEL), .PKT_DONE(PKT_DONE), .PKT_BEATS(PKT_BEATS),
        .PKT_BYTES(PKT_BYTES), .PKT_TID(PKT_TID), .PKT_TDEST(PKT_TDEST), .PKT_ERR(PKT_ERR)
    );

    int checks = 0;
    int errors = 0;

    // Beat layout in the model: {data[46:15], keep[14:11], last[10], dest[9:8], tid[7:0]}
    logic [46:0] fifo_q[$];
    logic [46:0] pkt_q[$];
    logic [8:0]  exp_beats;
    logic [10:0] exp_bytes;
    logic [7:0]  exp_tid;
    logic [1:0]  exp_dest;
    logic        exp_err;
    logic        exp_done;
    logic        last_push;
    bit          rand_rdy;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        fifo_q.delete();
        pkt_q.delete();
        exp_beats = '0;
        exp_bytes = '0;
        exp_tid   = '0;
        exp_dest  = '0;
        exp_err   = 1'b0;
        exp_done  = 1'b0;
    endtask

    // Statistics for a whole packet computed from its list of beats
    task automatic complete_packet();
        int n;
        int sum;
        logic e;
        n   = pkt_q.size();
        sum = 0;
        e   = 1'b0;
        for (int i = 0; i < n; i++) begin
            sum += $countones(pkt_q[i][14:11]);
            if (pkt_q[i][7:0] != pkt_q[0][7:0] || pkt_q[i][9:8] != pkt_q[0][9:8]) e = 1'b1;
        end
        if (n > MAX_BEATS) e = 1'b1;
        exp_beats = 9'((n > MAX_BEATS) ? MAX_BEATS : n);
        exp_bytes = 11'((sum > MAX_BYTES) ? MAX_BYTES : sum);
        exp_tid   = pkt_q[0][7:0];
        exp_dest  = pkt_q[0][9:8];
        exp_err   = e;
        exp_done  = 1'b1;
        pkt_q.delete();
    endtask

    // One clock: check pre-edge outputs, advance model, check post-edge outputs
    task automatic tick();
        logic do_push;
        logic do_pop;
        logic [46:0] cur;
        if (rand_rdy) M_TREADY = 1'($urandom_range(0, 1));
        @(negedge ACLK);
        check("s_tready", 64'(S_TREADY), 64'(fifo_q.size() != DEPTH));
        check("m_tvalid", 64'(M_TVALID), 64'(fifo_q.size() != 0));
        if (fifo_q.size() != 0)
            check("m_head", 64'({M_TDATA, M_TKEEP, M_TLAST, M_TDEST, M_TID}), 64'(fifo_q[0]));
        do_push = S_TVALID && (fifo_q.size() != DEPTH);
        do_pop  = M_TREADY && (fifo_q.size() != 0);
        cur     = {S_TDATA, S_TKEEP, S_TLAST, S_TDEST, S_TID};
        @(posedge ACLK);
        #1;
        exp_done = 1'b0;
        if (do_pop) void'(fifo_q.pop_front());
        if (do_push) begin
            fifo_q.push_back(cur);
            pkt_q.push_back(cur);
            if (cur[10]) complete_packet();
        end
        last_push = do_push;
        check("fifo_level", 64'(FIFO_LEVEL), 64'(fifo_q.size()));
        check("pkt_done", 64'(PKT_DONE), 64'(exp_done));
        check("pkt_beats", 64'(PKT_BEATS), 64'(exp_beats));
        check("pkt_bytes", 64'(PKT_BYTES), 64'(exp_bytes));
        check("pkt_tid", 64'(PKT_TID), 64'(exp_tid));
        check("pkt_tdest", 64'(PKT_TDEST), 64'(exp_dest));
        check("pkt_err", 64'(PKT_ERR), 64'(exp_err));
    endtask

    task automatic send_beat(input logic [3:0] k, input logic l, input logic [1:0] dst,
                             input logic [7:0] id);
        int guard;
        guard    = 0;
        S_TVALID = 1'b1;
        S_TDATA  = $urandom;
        S_TKEEP  = k;
        S_TLAST  = l;
        S_TDEST  = dst;
        S_TID    = id;
        last_push = 1'b0;
        while (!last_push && guard < 200) begin
            tick();
            guard++;
        end
        check("send_accept", 64'(last_push), 64'(1));
    endtask

    task automatic idle(input int n);
        S_TVALID = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drain();
        int guard;
        guard    = 0;
        S_TVALID = 1'b0;
        M_TREADY = 1'b1;
        rand_rdy = 1'b0;
        while (fifo_q.size() != 0 && guard < 100) begin
            tick();
            guard++;
        end
        check("drain_empty", 64'(fifo_q.size()), 64'(0));
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int len;
        logic [7:0] base_id;
        logic [1:0] base_dst;
        logic [7:0] id;

        RST = 1'b1;
        S_TVALID = 1'b0; S_TDATA = '0; S_TKEEP = '0; S_TLAST = 1'b0; S_TDEST = '0; S_TID = '0;
        M_TREADY = 1'b1;
        rand_rdy = 1'b0;
        last_push = 1'b0;
        model_reset();

        // Reset values
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_s_tready", 64'(S_TREADY), 64'(0));
        check("rst_m_tvalid", 64'(M_TVALID), 64'(0));
        check("rst_m_tdata", 64'(M_TDATA), 64'(0));
        check("rst_level", 64'(FIFO_LEVEL), 64'(0));
        check("rst_pkt_done", 64'(PKT_DONE), 64'(0));
        check("rst_pkt_beats", 64'(PKT_BEATS), 64'(0));
        RST = 1'b0;
        @(posedge ACLK);
        #1;
        check("rel_s_tready", 64'(S_TREADY), 64'(1));

        // 15-beat then 9-beat packet with full keep
        for (int b = 0; b < 15; b++) send_beat(4'hF, b == 14, 2'd2, 8'h12);
        check("p15_beats", 64'(PKT_BEATS), 64'(15));
        check("p15_bytes", 64'(PKT_BYTES), 64'(60));
        for (int b = 0; b < 9; b++) send_beat(4'hF, b == 8, 2'd2, 8'h12);
        check("p9_beats", 64'(PKT_BEATS), 64'(9));
        check("p9_bytes", 64'(PKT_BYTES), 64'(36));
        check("p9_err", 64'(PKT_ERR), 64'(0));
        drain();

        // Backpressure: fill to DEPTH, then release downstream
        M_TREADY = 1'b0;
        for (int b = 0; b < 16; b++) send_beat(4'hF, 1'b0, 2'd1, 8'h33);
        check("full_level", 64'(FIFO_LEVEL), 64'(16));
        check("full_s_tready", 64'(S_TREADY), 64'(0));
        M_TREADY = 1'b1;
        for (int b = 16; b < 20; b++) send_beat(4'hF, b == 19, 2'd1, 8'h33);
        drain();
        check("bp_pkt_beats", 64'(PKT_BEATS), 64'(20));

        // Partial keep bytes
        send_beat(4'hF, 1'b0, 2'd1, 8'h05);
        send_beat(4'h3, 1'b0, 2'd1, 8'h05);
        send_beat(4'h1, 1'b1, 2'd1, 8'h05);
        check("keep_bytes", 64'(PKT_BYTES), 64'(7));
        check("keep_beats", 64'(PKT_BEATS), 64'(3));

        // TID change mid-packet
        send_beat(4'hF, 1'b0, 2'd0, 8'h01);
        send_beat(4'hF, 1'b0, 2'd0, 8'h02);
        send_beat(4'hF, 1'b0, 2'd0, 8'h01);
        send_beat(4'hF, 1'b1, 2'd0, 8'h01);
        check("tid_err", 64'(PKT_ERR), 64'(1));
        check("tid_ref", 64'(PKT_TID), 64'(8'h01));

        // Back-to-back single-beat packets
        send_beat(4'h7, 1'b1, 2'd3, 8'hA0);
        check("single0_done", 64'(PKT_DONE), 64'(1));
        send_beat(4'h1, 1'b1, 2'd0, 8'hA1);
        check("single1_done", 64'(PKT_DONE), 64'(1));
        check("single1_tid", 64'(PKT_TID), 64'(8'hA1));
        idle(1);
        check("single_done_clear", 64'(PKT_DONE), 64'(0));

        // Oversized packet saturates and flags error
        for (int b = 0; b < 300; b++) send_beat(4'hF, b == 299, 2'd2, 8'h44);
        check("big_beats", 64'(PKT_BEATS), 64'(256));
        check("big_bytes", 64'(PKT_BYTES), 64'(1024));
        check("big_err", 64'(PKT_ERR), 64'(1));
        drain();

        // Reset mid-packet with 5 beats buffered
        M_TREADY = 1'b0;
        for (int b = 0; b < 5; b++) send_beat(4'hF, 1'b0, 2'd1, 8'h77);
        S_TVALID = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        check("mid_rst_m_tvalid", 64'(M_TVALID), 64'(0));
        check("mid_rst_level", 64'(FIFO_LEVEL), 64'(0));
        check("mid_rst_s_tready", 64'(S_TREADY), 64'(0));
        model_reset();
        @(posedge ACLK);
        #1;
        RST = 1'b0;
        @(posedge ACLK);
        #1;
        check("post_rst_pkt_done", 64'(PKT_DONE), 64'(0));
        M_TREADY = 1'b1;
        idle(2);
        send_beat(4'hF, 1'b0, 2'd2, 8'h09);
        send_beat(4'hF, 1'b1, 2'd2, 8'h09);
        check("post_rst_beats", 64'(PKT_BEATS), 64'(2));
        drain();

        // Randomized packets with random backpressure and gaps
        rand_rdy = 1'b1;
        for (int p = 0; p < 25; p++) begin
            len      = $urandom_range(1, 20);
            base_id  = 8'($urandom);
            base_dst = 2'($urandom);
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                id = ($urandom_range(0, 9) == 0) ? 8'($urandom) : base_id;
                send_beat(4'($urandom), b == len - 1, base_dst, id);
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4s_pkt_buffer.md
# axi4s_pkt_buffer

AXI4-Stream packet buffer and monitor that sits directly downstream of `axi4_stream`. It consumes the TDATA/TKEEP/TLAST/TDEST/TID beat stream and buffers it in a first-word-fall-through FIFO. The stream is re-presented unchanged on a master port that supports backpressure. For each packet, the block reports beat count, byte count, ID, destination and protocol-error status.

## Interface
- DATA_W, 32: TDATA width in bits; TKEEP width is DATA_W/8.
- DEPTH, 16: FIFO depth in beats; must be a power of two and at least 4.
- MAX_BEATS, 256: longest legal packet in beats.
- ACLK  in  1  single clock; all logic is on the rising edge.
- RST  in  1  asynchronous, active-high reset; clears all state.
- S_TVALID  in  1  upstream beat valid.
- S_TREADY  out  1  buffer can accept a beat.
- S_TDATA  in  DATA_W  beat data.
- S_TKEEP  in  DATA_W/8  byte enables.
- S_TLAST  in  1  last beat of the packet.
- S_TDEST  in  2  destination.
- S_TID  in  8  stream ID.
- M_TVALID  out  1  buffered beat available.
- M_TREADY  in  1  downstream accepts the beat.
- M_TDATA / M_TKEEP / M_TLAST / M_TDEST / M_TID  out  same widths as S_*  head-of-FIFO beat.
- FIFO_LEVEL  out  log2(DEPTH)+1  beats currently stored.
- PKT_DONE  out  1  one-cycle pulse when a packet's statistics are valid.
- PKT_BEATS  out  9  beat count of the last completed packet.
- PKT_BYTES  out  11  sum of set TKEEP bits over the last completed packet.
- PKT_TID / PKT_TDEST  out  8 / 2  ID and destination of the first beat of the last completed packet.
- PKT_ERR  out  1  the last completed packet violated a protocol rule.

## Operation
- Push occurs on S_TVALID & S_TREADY. Pop occurs on M_TVALID & M_TREADY. Push and pop may happen in the same cycle.
- Each FIFO entry holds {TDATA, TKEEP, TLAST, TDEST, TID}, stored unmodified. Output order equals input order.
- S_TREADY = (FIFO_LEVEL != DEPTH).
  - When the FIFO is full, no push occurs even if a pop happens in the same cycle.
  - S_TREADY rises the cycle after a pop from full.
- M_TVALID = (FIFO_LEVEL != 0). M_T* always reflect the head entry.
- While M_TVALID is high and M_TREADY is low, M_T* must hold stable.
- FIFO_LEVEL changes by +1 on push only, -1 on pop only, and 0 on both or neither. Pointers wrap modulo DEPTH.
- The ingress monitor has two states: IDLE and IN_PKT.
  - An accepted beat in IDLE latches TID/TDEST as the reference values, sets beats = 1 and bytes = popcount(TKEEP), and clears err.
  - If that beat has TLAST set, the packet completes immediately. Otherwise the state moves to IN_PKT.
  - In IN_PKT, each accepted beat adds 1 to beats and popcount(TKEEP) to bytes.
  - In IN_PKT, err is set if TID or TDEST differs from the reference values, or if the beat count would exceed MAX_BEATS.
  - Counters saturate at MAX_BEATS beats and MAX_BEATS*DATA_W/8 bytes.
  - TLAST returns the state to IDLE.
- On completion, PKT_BEATS, PKT_BYTES, PKT_TID, PKT_TDEST and PKT_ERR load, and PKT_DONE pulses. These statistics hold until the next completion.
- The monitor counts ingress beats only. Egress backpressure does not affect the statistics.

## Timing
- Reset values:
  - S_TREADY = 0 while RST is high, and 1 from the first cycle after release.
  - M_TVALID, M_T*, FIFO_LEVEL, PKT_* and PKT_DONE are all 0.
  - The monitor is in IDLE.
- Latency through an empty FIFO: a beat pushed at edge N is presented on M_T* with M_TVALID = 1 after edge N, so it is available for pop at edge N+1.
- PKT_DONE goes high in the cycle after the edge that accepted the TLAST beat, and lasts exactly 1 cycle. Its statistics are valid in that same cycle.
- Back-to-back single-beat packets produce a PKT_DONE in consecutive cycles.
- Sustained throughput is 1 beat per cycle when M_TREADY is held at 1.
- Reset mid-packet discards FIFO contents and the partial packet, with no PKT_DONE. Reset acts asynchronously and release is synchronous to ACLK.

## Test plan
- Reset, then a 15-beat packet followed by a 9-beat packet, TKEEP = 4'hF, TID = 8'h12, TDEST = 2, M_TREADY = 1 -> each output beat appears 1 cycle after its input beat. The packets produce PKT_BEATS 15 then 9, PKT_BYTES 60 then 36, and PKT_ERR = 0.
- M_TREADY = 0 while 20 beats are offered -> FIFO_LEVEL reaches 16 and S_TREADY drops after the 16th push. Then M_TREADY = 1 -> 20 beats emerge in order, S_TREADY rises 1 cycle after the first pop, and FIFO_LEVEL returns to 0.
- A 3-beat packet with TKEEP values F, 3 and 1 -> PKT_BYTES = 7 and PKT_BEATS = 3.
- TID changes from 8'h01 to 8'h02 on beat 2 of a 4-beat packet -> PKT_ERR = 1, PKT_TID = 8'h01, and the data still passes through unmodified.
- A 300-beat packet with MAX_BEATS = 256 -> PKT_BEATS = 256, PKT_BYTES = 1024, PKT_ERR = 1.
- Assert RST mid-packet with 5 beats buffered -> M_TVALID drops immediately and FIFO_LEVEL = 0. After release, no PKT_DONE occurs, and a new 2-beat packet reports PKT_BEATS = 2.
